// File: rtl/m_axis_rc_realign.sv
// Realigns the 512-bit legacy RC completion stream: strips the 3-DW header into registered
// sideband fields and shifts the payload down by 3 DW, adding a flush beat when needed.
module m_axis_rc_realign #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] m_axis_rc_tdata,
  input  logic [KEEP_WIDTH-1:0] m_axis_rc_tkeep,
  input  logic                  m_axis_rc_tlast,
  input  logic [84:0]           m_axis_rc_tuser,
  input  logic                  m_axis_rc_tvalid,
  output logic [3:0]            m_axis_rc_tready,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic                  source_first,
  output logic                  source_last,
  output logic [DATA_WIDTH-1:0] source_dat,
  output logic [KEEP_WIDTH-1:0] source_be,
  output logic [9:0]            hdr_len,
  output logic                  hdr_with_data,
  output logic [2:0]            hdr_status,
  output logic [11:0]           hdr_bytecnt,
  output logic [15:0]           hdr_cplid,
  output logic [15:0]           hdr_reqid,
  output logic [7:0]            hdr_tag,
  output logic [6:0]            hdr_lowaddr,
  output logic                  hdr_err
);

  typedef enum logic [1:0] {StSop, StBody, StFlush} state_e;

  state_e        state_q, state_d;
  logic [415:0]  carry_q, carry_d;
  logic [12:0]   carry_mask_q, carry_mask_d;
  logic          first_pend_q, first_pend_d;
  logic          err_acc_q, err_acc_d;
  logic [95:0]   hdr_q, hdr_d;
  logic          hdr_err_q, hdr_err_d;
  logic          src_valid_q, src_valid_d;
  logic          src_first_q, src_first_d;
  logic          src_last_q, src_last_d;
  logic [511:0]  src_dat_q, src_dat_d;
  logic [15:0]   src_mask_q, src_mask_d;

  logic          can_load, rdy, acc, err_new;
  logic [15:0]   dw_mask;

  // keep is DW-granular; bit 4*i stands for the whole DW
  always_comb begin
    dw_mask = '0;
    for (int i = 0; i < 16; i++) dw_mask[i] = m_axis_rc_tkeep[4*i];
  end

  always_comb begin
    can_load     = !src_valid_q || source_ready;
    rdy          = can_load && (state_q != StFlush) && !user_reset;
    acc          = m_axis_rc_tvalid && rdy;
    err_new      = 1'b0;
    state_d      = state_q;
    carry_d      = carry_q;
    carry_mask_d = carry_mask_q;
    first_pend_d = first_pend_q;
    err_acc_d    = err_acc_q;
    hdr_d        = hdr_q;
    hdr_err_d    = hdr_err_q;
    src_valid_d  = can_load ? 1'b0 : src_valid_q;
    src_first_d  = src_first_q;
    src_last_d   = src_last_q;
    src_dat_d    = src_dat_q;
    src_mask_d   = src_mask_q;

    unique case (state_q)
      StSop: begin
        if (acc) begin
          hdr_d     = m_axis_rc_tdata[95:0];
          err_new   = m_axis_rc_tuser[1] | m_axis_rc_tuser[0];
          err_acc_d = err_new;
          if (m_axis_rc_tlast) begin
            src_valid_d = 1'b1;
            src_first_d = 1'b1;
            src_last_d  = 1'b1;
            src_dat_d   = {96'b0, m_axis_rc_tdata[511:96]};
            src_mask_d  = {3'b0, dw_mask[15:3]};
            hdr_err_d   = err_new;
          end else begin
            carry_d      = m_axis_rc_tdata[511:96];
            carry_mask_d = dw_mask[15:3];
            first_pend_d = 1'b1;
            state_d      = StBody;
          end
        end
      end
      StBody: begin
        if (acc) begin
          err_new      = err_acc_q | m_axis_rc_tuser[0];
          err_acc_d    = err_new;
          src_valid_d  = 1'b1;
          src_first_d  = first_pend_q;
          src_last_d   = 1'b0;
          src_dat_d    = {m_axis_rc_tdata[95:0], carry_q};
          src_mask_d   = {dw_mask[2:0], 13'h1fff};
          hdr_err_d    = err_new;
          first_pend_d = 1'b0;
          if (!m_axis_rc_tlast || dw_mask[3]) begin
            // remaining DW3.. either continue the packet or drain in a flush beat
            carry_d      = m_axis_rc_tdata[511:96];
            carry_mask_d = dw_mask[15:3];
          end
          if (m_axis_rc_tlast) begin
            if (dw_mask[3]) begin
              state_d = StFlush;
            end else begin
              src_last_d = 1'b1;
              state_d    = StSop;
            end
          end
        end
      end
      StFlush: begin
        if (can_load) begin
          src_valid_d = 1'b1;
          src_first_d = 1'b0;
          src_last_d  = 1'b1;
          src_dat_d   = {96'b0, carry_q};
          src_mask_d  = {3'b0, carry_mask_q};
          hdr_err_d   = err_acc_q;
          state_d     = StSop;
        end
      end
      default: state_d = StSop;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q      <= StSop;
      carry_q      <= '0;
      carry_mask_q <= '0;
      first_pend_q <= 1'b0;
      err_acc_q    <= 1'b0;
      hdr_q        <= '0;
      hdr_err_q    <= 1'b0;
      src_valid_q  <= 1'b0;
      src_first_q  <= 1'b0;
      src_last_q   <= 1'b0;
      src_dat_q    <= '0;
      src_mask_q   <= '0;
    end else begin
      state_q      <= state_d;
      carry_q      <= carry_d;
      carry_mask_q <= carry_mask_d;
      first_pend_q <= first_pend_d;
      err_acc_q    <= err_acc_d;
      hdr_q        <= hdr_d;
      hdr_err_q    <= hdr_err_d;
      src_valid_q  <= src_valid_d;
      src_first_q  <= src_first_d;
      src_last_q   <= src_last_d;
      src_dat_q    <= src_dat_d;
      src_mask_q   <= src_mask_d;
    end
  end

  always_comb begin
    source_be = '0;
    for (int i = 0; i < 16; i++) source_be[4*i +: 4] = {4{src_mask_q[i]}};
  end

  assign m_axis_rc_tready = {4{rdy}};
  assign source_valid     = src_valid_q;
  assign source_first     = src_first_q;
  assign source_last      = src_last_q;
  assign source_dat       = src_dat_q;
  assign hdr_len          = hdr_q[9:0];
  assign hdr_with_data    = hdr_q[30];
  assign hdr_status       = hdr_q[47:45];
  assign hdr_bytecnt      = hdr_q[43:32];
  assign hdr_cplid        = hdr_q[63:48];
  assign hdr_reqid        = hdr_q[95:80];
  assign hdr_tag          = hdr_q[79:72];
  assign hdr_lowaddr      = hdr_q[70:64];
  assign hdr_err          = hdr_err_q;

  logic unused_bits;
  assign unused_bits = ^{m_axis_rc_tuser[84:2], m_axis_rc_tkeep, hdr_q[29:10], hdr_q[31],
                         hdr_q[44], hdr_q[71]};

endmodule

// File: tb/tb_m_axis_rc_realign.sv
// Randomized bench for m_axis_rc_realign: packets are built as DW lists and the expected output
// beats come from slicing the payload into 16-DW chunks.
module tb_m_axis_rc_realign;

  logic         user_clk = 1'b0;
  logic         user_reset = 1'b1;
  logic [511:0] m_axis_rc_tdata = '0;
  logic [63:0]  m_axis_rc_tkeep = '0;
  logic         m_axis_rc_tlast = 1'b0;
  logic [84:0]  m_axis_rc_tuser = '0;
  logic         m_axis_rc_tvalid = 1'b0;
  logic [3:0]   m_axis_rc_tready;
  logic         source_valid, source_ready = 1'b0, source_first, source_last;
  logic [511:0] source_dat;
  logic [63:0]  source_be;
  logic [9:0]   hdr_len;
  logic         hdr_with_data, hdr_err;
  logic [2:0]   hdr_status;
  logic [11:0]  hdr_bytecnt;
  logic [15:0]  hdr_cplid, hdr_reqid;
  logic [7:0]   hdr_tag;
  logic [6:0]   hdr_lowaddr;

  always #5 user_clk = ~user_clk;

  m_axis_rc_realign dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .m_axis_rc_tdata(m_axis_rc_tdata), .m_axis_rc_tkeep(m_axis_rc_tkeep),
    .m_axis_rc_tlast(m_axis_rc_tlast), .m_axis_rc_tuser(m_axis_rc_tuser),
    .m_axis_rc_tvalid(m_axis_rc_tvalid), .m_axis_rc_tready(m_axis_rc_tready),
    .source_valid(source_valid), .source_ready(source_ready), .source_first(source_first),
    .source_last(source_last), .source_dat(source_dat), .source_be(source_be),
    .hdr_len(hdr_len), .hdr_with_data(hdr_with_data), .hdr_status(hdr_status),
    .hdr_bytecnt(hdr_bytecnt), .hdr_cplid(hdr_cplid), .hdr_reqid(hdr_reqid),
    .hdr_tag(hdr_tag), .hdr_lowaddr(hdr_lowaddr), .hdr_err(hdr_err)
  );

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic [84:0]  user;
  } in_beat_t;

  typedef struct packed {
    logic [511:0] dat;
    logic [63:0]  be;
    logic         first;
    logic         last;
    logic         err;
    logic [72:0]  hdr;
  } out_beat_t;

  in_beat_t  in_q[$];
  out_beat_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int ready_mode = 0;  // 0: always ready, 1: random backpressure, 2: never ready
  int stall_cycles = 0;
  int flushes = 0;
  int tready_split = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] be_of(input int k);
    logic [63:0] b = '0;
    for (int i = 0; i < k; i++) b[4*i +: 4] = 4'hf;
    return b;
  endfunction

  function automatic logic [511:0] bits_of(input logic [63:0] be);
    logic [511:0] m = '0;
    for (int i = 0; i < 64; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic gen_pkt(input int plen, input logic [2:0] status, input logic [7:0] tag,
                         input bit poison, input int disc_beat);
    logic [31:0] dws[$];
    logic [31:0] payload[$];
    logic [9:0]  len10;
    logic [11:0] bytecnt;
    logic [15:0] cplid, reqid;
    logic [6:0]  lowaddr;
    logic        wd;
    in_beat_t    ib;
    out_beat_t   ob;
    int          nb, no, sz;
    len10   = plen[9:0];
    wd      = (plen != 0);
    bytecnt = 12'($urandom);
    cplid   = 16'($urandom);
    reqid   = 16'($urandom);
    lowaddr = 7'($urandom);
    for (int i = 0; i < plen; i++) payload.push_back($urandom);
    dws.push_back({1'b0, wd, 20'($urandom), len10});
    dws.push_back({cplid, status, 1'b0, bytecnt});
    dws.push_back({reqid, tag, 1'b0, lowaddr});
    foreach (payload[i]) dws.push_back(payload[i]);
    nb = (dws.size() + 15) / 16;
    for (int b = 0; b < nb; b++) begin
      ib.keep = '0;
      for (int i = 0; i < 16; i++) begin
        ib.data[32*i +: 32] = $urandom;
        if (b * 16 + i < dws.size()) begin
          ib.data[32*i +: 32] = dws[b * 16 + i];
          ib.keep[4*i +: 4]   = 4'hf;
        end
      end
      ib.last    = (b == nb - 1);
      ib.user    = 85'({$urandom, $urandom, $urandom});
      ib.user[1] = (b == 0) && poison;
      ib.user[0] = (b == disc_beat);
      in_q.push_back(ib);
    end
    no = (plen == 0) ? 1 : (plen + 15) / 16;
    if (no == nb && nb > 1) flushes++;
    for (int k = 0; k < no; k++) begin
      sz = plen - 16 * k;
      if (sz > 16) sz = 16;
      ob.dat = '0;
      for (int i = 0; i < sz; i++) ob.dat[32*i +: 32] = payload[16 * k + i];
      ob.be    = be_of(sz);
      ob.first = (k == 0);
      ob.last  = (k == no - 1);
      ob.err   = poison || (disc_beat >= 0 && disc_beat < nb);
      ob.hdr   = {len10, wd, status, bytecnt, cplid, reqid, tag, lowaddr};
      exp_q.push_back(ob);
    end
  endtask

  task automatic step();
    out_beat_t e;
    @(negedge user_clk);
    source_ready = (ready_mode == 0) ? 1'b1 :
                   (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    if (in_q.size() > 0) begin
      m_axis_rc_tvalid = 1'b1;
      m_axis_rc_tdata  = in_q[0].data;
      m_axis_rc_tkeep  = in_q[0].keep;
      m_axis_rc_tlast  = in_q[0].last;
      m_axis_rc_tuser  = in_q[0].user;
    end else begin
      m_axis_rc_tvalid = 1'b0;
      m_axis_rc_tdata  = {16{$urandom}};
    end
    #1;
    if (m_axis_rc_tready !== {4{m_axis_rc_tready[0]}}) tready_split++;
    if (m_axis_rc_tready[0] !== 1'b1) stall_cycles++;
    if (source_valid && source_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("dat", source_dat & bits_of(e.be), e.dat);
        check("be", source_be, e.be);
        check("first", source_first, e.first);
        check("last", source_last, e.last);
        check("hdr", {hdr_len, hdr_with_data, hdr_status, hdr_bytecnt, hdr_cplid, hdr_reqid,
                      hdr_tag, hdr_lowaddr}, e.hdr);
        if (e.last) check("hdr_err", hdr_err, e.err);
      end
    end
    if (m_axis_rc_tvalid && m_axis_rc_tready[0]) void'(in_q.pop_front());
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && c < budget) begin
      step();
      c++;
    end
    check("drain_left", in_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nb;
    int c;
    repeat (3) @(negedge user_clk);
    #1;
    check("rst_tready", m_axis_rc_tready, 4'h0);
    check("rst_valid", source_valid, 1'b0);
    check("rst_hdr", {hdr_len, hdr_tag, hdr_cplid, hdr_err}, '0);
    @(negedge user_clk);
    user_reset = 1'b0;
    #1;
    check("post_rst_tready", m_axis_rc_tready, 4'hf);

    // Directed shapes plus random lengths at full throughput; only flushes may stall input.
    ready_mode = 0;
    stall_cycles = 0;
    flushes = 0;
    gen_pkt(4, 3'($urandom), 8'($urandom), 1'b0, -1);
    gen_pkt(0, 3'b001, 8'h5a, 1'b0, -1);
    gen_pkt(16, 3'b000, 8'($urandom), 1'b0, -1);
    gen_pkt(20, 3'b000, 8'($urandom), 1'b0, -1);
    for (int i = 0; i < 10; i++)
      gen_pkt($urandom_range(0, 60), 3'($urandom), 8'($urandom), $urandom_range(0, 3) == 0,
              int'($urandom_range(0, 4)) - 1);
    drain(2000);
    check("flush_bubbles", stall_cycles, flushes);

    // Discontinue on beat 2 of a 3-beat packet, then random traffic, under backpressure.
    ready_mode = 1;
    gen_pkt(35, 3'b000, 8'h33, 1'b0, 1);
    for (int i = 0; i < 25; i++)
      gen_pkt($urandom_range(0, 60), 3'($urandom), 8'($urandom), $urandom_range(0, 3) == 0,
              int'($urandom_range(0, 4)) - 1);
    drain(8000);

    // Reset while the flush beat is pending.
    ready_mode = 0;
    gen_pkt(20, 3'b000, 8'h11, 1'b0, -1);
    c = 0;
    while (in_q.size() > 0 && c < 100) begin
      step();
      c++;
    end
    check("flush_setup_left", in_q.size(), 0);
    @(negedge user_clk);
    source_ready = 1'b0;
    m_axis_rc_tvalid = 1'b0;
    #1;
    check("flush_tready", m_axis_rc_tready, 4'h0);
    check("flush_held_valid", source_valid, 1'b1);
    user_reset = 1'b1;
    @(negedge user_clk);
    user_reset = 1'b0;
    #1;
    check("rst_flush_valid", source_valid, 1'b0);
    check("rst_flush_tready", m_axis_rc_tready, 4'hf);
    exp_q.delete();
    gen_pkt(20, 3'b010, 8'h22, 1'b1, -1);
    nb = 0;
    drain(200);
    check("tready_bits_equal", tready_split, nb);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/m_axis_rc_realign.md
Name: m_axis_rc_realign

Overview:
- Sits directly downstream of the x16 RC adapter, between it and the LitePCIe completion depacketizer.
- Takes the 512-bit legacy-format completion stream, which carries a 3-DW header in DW0..DW2 of the first beat.
- Extracts the header fields into registered sideband outputs.
- Shifts the payload down by 3 DW so that payload DW0 lands in output DW0, adding a trailing flush beat when needed.

Parameters:
DATA_WIDTH, 512, stream data width in bits; only 512 is supported.
KEEP_WIDTH, DATA_WIDTH/8, byte-enable width.

Ports:
user_clk  in  1  clock.
user_reset  in  1  synchronous, active-high reset.
m_axis_rc_tdata  in  512  adapted completion stream data.
m_axis_rc_tkeep  in  64  byte enables; valid in DW-aligned groups of 4; bit 4*i marks DW i valid.
m_axis_rc_tlast  in  1  end of packet.
m_axis_rc_tuser  in  85  bit1 = poisoned, bit0 = discontinue; other bits ignored.
m_axis_rc_tvalid  in  1  input beat valid.
m_axis_rc_tready  out  4  accept; all 4 bits identical.
source_valid  out  1  output beat valid.
source_ready  in  1  downstream accept.
source_first  out  1  first output beat of packet.
source_last  out  1  last output beat of packet.
source_dat  out  512  realigned payload.
source_be  out  64  byte enables of realigned payload.
hdr_len  out  10  header DW0[9:0].
hdr_with_data  out  1  fmt bit 30.
hdr_status  out  3  header bits [47:45].
hdr_bytecnt  out  12  header bits [43:32].
hdr_cplid  out  16  header bits [63:48].
hdr_reqid  out  16  header bits [95:80].
hdr_tag  out  8  header bits [79:72].
hdr_lowaddr  out  7  header bits [70:64].
hdr_err  out  1  poisoned OR discontinue seen anywhere in the packet.

Behaviour:
- Reset: all outputs 0, m_axis_rc_tready 0 during reset; state = SOP; carry registers cleared. A reset mid-packet discards the packet with no partial output. On the first cycle after reset, tready is 1.
- Output stage is a single register. `can_load = !source_valid || source_ready`.
- Input accepted (`acc`) when `m_axis_rc_tvalid && tready`, where `tready = can_load && state != FLUSH`.

Let n = number of valid DWs in an accepted beat, taken from the keep DW mask, which is contiguous from DW0.

State SOP (expecting the first beat):
- On acc, latch all hdr_* fields from tdata[95:0]. Set `err_acc = tuser[1] | tuser[0]`.
- If tlast: load the output with DW3..n-1 shifted to DW0 (`be` = n-3 DWs; 0 when n = 3, i.e. completion without data), first = 1, last = 1. Stay in SOP.
- Else: store DW3..15 in the carry register (13 DWs), set first_pending = 1, go to BODY. No output is produced.

State BODY:
- On acc: output = {cur DW0..2, carry DW0..12}. `be` covers 13 + min(n,3) DWs. first = first_pending, then clear first_pending. `err_acc |= tuser[0]`.
- If !tlast: carry = cur DW3..15.
- If tlast and n ≤ 3: last = 1, go to SOP.
- If tlast and n > 3: last = 0, carry = cur DW3..n-1 (n-3 DWs), go to FLUSH.

State FLUSH:
- tready = 0.
- When can_load: output = carry, be = carry DW count, last = 1, first = 0. Go to SOP.

Sideband and timing:
- hdr_err is driven as err_acc and is updated with every loaded beat. It is final on the last beat.
- hdr_* are stable from the first output beat through the last.
- Latency: single-beat packet → output 1 cycle after acc. Multi-beat packet → output 1 cycle after the second acc. Flush beat → next cycle when can_load.
- source_* holds stable while source_valid && !source_ready.
- Back-to-back packets: a new SOP beat may be accepted in the same cycle the previous last beat is consumed.
- Throughput: 1 beat/cycle, except one bubble per flush.

Test Plan:
- Single-beat CplD, n = 7, payload DWs A..D → one beat, dat DW0..3 = A..D, be = 0x0000_FFFF, first = last = 1.
- Cpl without data, n = 3, status = 3'b001, tag = 0x5A → one beat, be = 0, first = last = 1, hdr_with_data = 0, hdr_status = 1, hdr_tag = 0x5A.
- Two beats, n = 16 then n = 3 (16-DW payload P0..P15) → one beat, be all ones, dat DWi = Pi, first = last = 1.
- Two beats, n = 16 then n = 7 (20-DW payload) → two output beats: be all ones (P0..P15), then be = 0xFFFF (P16..P19) with last = 1. Input tready is 0 for exactly the flush cycle.
- Discontinue asserted on beat 2 of a 3-beat packet, with random source_ready backpressure → hdr_err = 1 on the last beat. Data is identical to the no-backpressure run, with no beat lost or duplicated.
- user_reset pulsed while in FLUSH → source_valid 0 the next cycle, state SOP. The following packet is output correctly with first = 1.
